ubuf_axil_bridge: RTL and testbench
===================================

# ubuf_axil_bridge

AXI4-Lite slave that acts as the initiator on the unified buffer's simple host port (`axi_ubuf_en/we/addr/wdata/rdata`). It converts one host transaction at a time into a single-cycle buffer access and returns the write response or the registered read data.
It sits between the SoC interconnect and the unified buffer, and is the only driver of that port.

## Interface
- `ADDR_W`, 32: AXI byte-address width.
- `UB_WORD_LIMIT`, 16'h29FF: highest valid buffer word address. Weight, input and misc regions are contiguous from word 0.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `s_awvalid`/`s_awready` in/out 1, `s_awaddr` in ADDR_W: write address channel.
- `s_wvalid`/`s_wready` in/out 1, `s_wdata` in 64, `s_wstrb` in 8: write data channel.
- `s_bvalid` out 1, `s_bready` in 1, `s_bresp` out 2: write response channel.
- `s_arvalid`/`s_arready` in/out 1, `s_araddr` in ADDR_W: read address channel.
- `s_rvalid` out 1, `s_rready` in 1, `s_rdata` out 64, `s_rresp` out 2: read data channel.
- `axi_ubuf_en` out 1: buffer access strobe, exactly one cycle per access.
- `axi_ubuf_we` out 1: 1 = write, 0 = read.
- `axi_ubuf_addr` out 16: word address, equal to byte address bits [18:3].
- `axi_ubuf_wdata` out 64: write data.
- `axi_ubuf_rdata` in 64: read data, valid the cycle after a read strobe.

## Operation
**Holding registers**
- There is one AW, one W and one AR holding register, each with a full flag.
- `s_awready` = !aw_full, `s_wready` = !w_full, `s_arready` = !ar_full (combinational).
- AW and W may arrive in either order or in the same cycle.

**FSM states**
- IDLE:
  - A write is eligible when aw_full && w_full.
  - A read is eligible when ar_full.
  - If both are eligible, grant the type not granted last. After reset, write wins first.
  - Granted write: register en=1, we=1, addr, wdata; clear aw_full/w_full; go to WR_RESP.
  - Granted read: register en=1, we=0, addr; clear ar_full; go to RD_WAIT.
- RD_WAIT: capture `axi_ubuf_rdata` into `s_rdata`, set rvalid, go to RD_RESP.
- WR_RESP: hold bvalid until `s_bready`, then go to IDLE.
- RD_RESP: hold rvalid until `s_rready`, then go to IDLE.

**Error checks**
- If the word address is > UB_WORD_LIMIT, or byte-address bits [2:0] are nonzero, or ADDR_W bits above [18] are nonzero, the access is illegal.
  - Illegal access: en is not asserted. The FSM still passes through RD_WAIT/WR_RESP with timing identical to a legal access. Response is SLVERR (2'b10). Read data is 0.
- For writes, wstrb != 8'hFF also gives SLVERR with no buffer write, because the buffer has no byte mask.
- Legal access: resp = OKAY (2'b00).

**Other rules**
- Only one transaction is outstanding. New AW/W/AR are accepted into empty holding registers while a response is pending.
- `axi_ubuf_addr`/`axi_ubuf_wdata` keep their last value when en=0. `axi_ubuf_we` is 0 whenever en=0.

## Timing
**Reset values**
- readies 1; bvalid/rvalid 0; bresp/rresp 0; rdata 0.
- en/we 0; addr/wdata 0; FSM IDLE; all full flags 0; last-grant = read, so write wins first.

**Latency**
- Write: AW+W handshake at edge T, en/we high in cycle T+1, bvalid high from cycle T+2.
- Read: AR handshake at edge T, en high (we=0) in cycle T+1, buffer data during T+2, rvalid/rdata from cycle T+3.

**Handshake rules**
- Back-to-back: the first strobe for the next transaction occurs in the cycle after the B/R handshake edge.
- bvalid/rvalid and their resp/data stay stable until handshake.
- Ready/valid may be asserted at the same edge as a holding register is cleared.
- A handshake on the same edge where the register is cleared is accepted.

**Reset mid-operation**
- Reset asynchronously forces en=0 and abandons any held or pending transaction; no response is produced.

## Structure
- Package `ubuf_axil_pkg`:
  - state enum {IDLE, RD_WAIT, WR_RESP, RD_RESP};
  - resp constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - UB_WORD_LIMIT default;
  - function `ub_addr_legal(addr)`.
- One natural sub-module: `axil_hold_reg`, a parameterised width data register with full flag and ready = !full.
  - Instantiated three times (AW, W+WSTRB, AR).

## Test plan
- Write byte addr 0x0001_0000 (word 0x2000), wstrb FF, data 64'hDEAD_BEEF_0123_4567 -> en=1, we=1, addr 16'h2000 one cycle later; bresp OKAY the cycle after that.
- Read word 0x2000 with buffer model returning that data -> en=1, we=0; rvalid 2 cycles after the strobe with rdata 64'hDEAD_BEEF_0123_4567, rresp OKAY.
- Read byte addr 0x0001_5000 (word 0x2A00) -> no en pulse, rresp SLVERR, rdata 0, same latency as a legal read. Write with wstrb 8'h0F -> no en pulse, bresp SLVERR.
- AW, W and AR all valid in the first cycle after reset -> write is issued first, then read. With both pending again -> read is issued before write.
- Hold bready low 5 cycles -> bvalid/bresp stable, no further en pulse. Meanwhile an AR is accepted and issued the cycle after the B handshake.
- Assert rst during the en=1 write cycle -> en drops immediately, all outputs return to reset values, no bvalid afterwards.

Source files
------------

// File: rtl/ubuf_axil_pkg.sv
// ubuf_axil_pkg
// Shared types and helpers for the AXI4-Lite to unified-buffer bridge.
//   state_t               : bridge FSM states
//   RESP_OKAY/RESP_SLVERR : AXI response codes
//   UB_WORD_LIMIT_DEFAULT : highest valid buffer word address
//   ub_addr_legal()       : legality check of a zero-extended byte address
package ubuf_axil_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_RESP = 2'd2,
        RD_RESP = 2'd3
    } state_t;

    localparam logic [1:0]  RESP_OKAY             = 2'b00;
    localparam logic [1:0]  RESP_SLVERR           = 2'b10;
    localparam logic [15:0] UB_WORD_LIMIT_DEFAULT = 16'h29FF;

    // The byte address must be 8-byte aligned, carry nothing above bit 18,
    // and land on a word at or below the buffer's last word.
    function automatic logic ub_addr_legal(
        input logic [63:0] byte_addr,
        input logic [15:0] word_limit = UB_WORD_LIMIT_DEFAULT
    );
        return (byte_addr[2:0] == 3'b000) &&
               (byte_addr[63:19] == '0) &&
               (byte_addr[18:3] <= word_limit);
    endfunction

endpackage

// File: rtl/ubuf_axil_bridge_hold.sv
// axil_hold_reg
// One-deep holding register for an AXI channel payload.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : channel valid; payload captured when the register is empty
//   in_data    : channel payload
//   ready      : channel ready (= !full)
//   clear      : consumer has taken the payload; empties the register
//   full, data : held payload and its occupancy flag
module axil_hold_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         ready,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] data
);

    logic         full_reg;
    logic [W-1:0] data_reg;

    // Load and clear never coincide: clear is only raised while full, and a
    // load only happens while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (in_valid && !full_reg) begin
            full_reg <= 1'b1;
            data_reg <= in_data;
        end else if (clear) begin
            full_reg <= 1'b0;
        end
    end

    assign ready = !full_reg;
    assign full  = full_reg;
    assign data  = data_reg;

endmodule

// File: rtl/ubuf_axil_bridge.sv
// ubuf_axil_bridge
// AXI4-Lite slave driving the unified buffer's simple host port. One host
// transaction at a time becomes a single-cycle buffer access; the bridge
// returns the write response or the registered read data.
//   clk, rst                          : clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*/s_ar*/s_r*        : AXI4-Lite slave channels (64-bit data)
//   axi_ubuf_en/we/addr/wdata         : buffer access strobe and payload
//   axi_ubuf_rdata                    : buffer read data, valid the cycle after a read strobe
module ubuf_axil_bridge
    import ubuf_axil_pkg::*;
#(
    parameter int          ADDR_W        = 32,
    parameter logic [15:0] UB_WORD_LIMIT = UB_WORD_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [63:0]       s_wdata,
    input  logic [7:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [63:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              axi_ubuf_en,
    output logic              axi_ubuf_we,
    output logic [15:0]       axi_ubuf_addr,
    output logic [63:0]       axi_ubuf_wdata,
    input  logic [63:0]       axi_ubuf_rdata
);

    logic              aw_full, w_full, ar_full;
    logic [ADDR_W-1:0] aw_addr, ar_addr;
    logic [71:0]       w_data;
    logic              grant_wr, grant_rd;
    logic              wr_legal, rd_legal;

    state_t      state_reg;
    logic        last_wr_reg;
    logic        rd_armed_reg;
    logic        rd_legal_reg;
    logic        en_reg, we_reg;
    logic [15:0] addr_reg;
    logic [63:0] wdata_reg;
    logic        bvalid_reg, rvalid_reg;
    logic [1:0]  bresp_reg, rresp_reg;
    logic [63:0] rdata_reg;

    axil_hold_reg #(.W(ADDR_W)) u_aw_hold (
        .clk(clk), .rst(rst),
        .in_valid(s_awvalid), .in_data(s_awaddr), .ready(s_awready),
        .clear(grant_wr), .full(aw_full), .data(aw_addr)
    );

    axil_hold_reg #(.W(72)) u_w_hold (
        .clk(clk), .rst(rst),
        .in_valid(s_wvalid), .in_data({s_wstrb, s_wdata}), .ready(s_wready),
        .clear(grant_wr), .full(w_full), .data(w_data)
    );

    axil_hold_reg #(.W(ADDR_W)) u_ar_hold (
        .clk(clk), .rst(rst),
        .in_valid(s_arvalid), .in_data(s_araddr), .ready(s_arready),
        .clear(grant_rd), .full(ar_full), .data(ar_addr)
    );

    // Round-robin between the two request types when both are waiting.
    assign grant_wr = (state_reg == IDLE) && aw_full && w_full &&
                      (!ar_full || !last_wr_reg);
    assign grant_rd = (state_reg == IDLE) && ar_full && !grant_wr;

    // The buffer has no byte mask, so only full-word writes are performed.
    assign wr_legal = ub_addr_legal(64'(aw_addr), UB_WORD_LIMIT) &&
                      (w_data[71:64] == 8'hFF);
    assign rd_legal = ub_addr_legal(64'(ar_addr), UB_WORD_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            last_wr_reg  <= 1'b0;
            rd_armed_reg <= 1'b0;
            rd_legal_reg <= 1'b0;
            en_reg       <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            rvalid_reg   <= 1'b0;
            rresp_reg    <= RESP_OKAY;
            rdata_reg    <= '0;
        end else begin
            // The strobe lasts exactly one cycle.
            en_reg <= 1'b0;
            we_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_wr) begin
                        en_reg      <= wr_legal;
                        we_reg      <= wr_legal;
                        if (wr_legal) begin
                            addr_reg  <= aw_addr[18:3];
                            wdata_reg <= w_data[63:0];
                        end
                        bresp_reg   <= wr_legal ? RESP_OKAY : RESP_SLVERR;
                        last_wr_reg <= 1'b1;
                        state_reg   <= WR_RESP;
                    end else if (grant_rd) begin
                        en_reg       <= rd_legal;
                        if (rd_legal) begin
                            addr_reg <= ar_addr[18:3];
                        end
                        rd_legal_reg <= rd_legal;
                        rd_armed_reg <= 1'b0;
                        last_wr_reg  <= 1'b0;
                        state_reg    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // First cycle here is the strobe cycle itself; the buffer
                    // data is only present in the cycle after it.
                    if (!rd_armed_reg) begin
                        rd_armed_reg <= 1'b1;
                    end else begin
                        rdata_reg  <= rd_legal_reg ? axi_ubuf_rdata : 64'h0;
                        rresp_reg  <= rd_legal_reg ? RESP_OKAY : RESP_SLVERR;
                        rvalid_reg <= 1'b1;
                        state_reg  <= RD_RESP;
                    end
                end
                WR_RESP: begin
                    // bvalid rises the cycle after the strobe cycle.
                    if (!bvalid_reg) begin
                        bvalid_reg <= 1'b1;
                    end else if (s_bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                RD_RESP: begin
                    if (s_rready) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign axi_ubuf_en    = en_reg;
    assign axi_ubuf_we    = we_reg;
    assign axi_ubuf_addr  = addr_reg;
    assign axi_ubuf_wdata = wdata_reg;
    assign s_bvalid       = bvalid_reg;
    assign s_bresp        = bresp_reg;
    assign s_rvalid       = rvalid_reg;
    assign s_rresp        = rresp_reg;
    assign s_rdata        = rdata_reg;

endmodule

// File: tb/tb_ubuf_axil_bridge.sv
// tb_ubuf_axil_bridge
// Directed and randomized checks of ubuf_axil_bridge against a reference
// model of buffer contents and address rules, plus a simple buffer model.
module tb_ubuf_axil_bridge;

    logic        clk, rst;
    logic        s_awvalid, s_awready;
    logic [31:0] s_awaddr;
    logic        s_wvalid, s_wready;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic        s_rvalid, s_rready;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        axi_ubuf_en, axi_ubuf_we;
    logic [15:0] axi_ubuf_addr;
    logic [63:0] axi_ubuf_wdata;
    logic [63:0] axi_ubuf_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int exp_en = 0;
    int en_seen = 0;
    logic [16:0] en_log [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ubuf_axil_bridge #(.ADDR_W(32), .UB_WORD_LIMIT(16'h29FF)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .axi_ubuf_en(axi_ubuf_en), .axi_ubuf_we(axi_ubuf_we),
        .axi_ubuf_addr(axi_ubuf_addr), .axi_ubuf_wdata(axi_ubuf_wdata),
        .axi_ubuf_rdata(axi_ubuf_rdata)
    );

    // Never-written words hold a recognisable address-derived pattern.
    function automatic logic [63:0] init_pat(input logic [15:0] w);
        return {w, ~w, w ^ 16'hA5A5, w + 16'h1234};
    endfunction

    // Unified buffer: registered read, one-cycle write.
    logic [63:0] ub_mem [int];
    logic [63:0] ub_rdata_q = 64'h0;
    always @(posedge clk) begin
        if (axi_ubuf_en) begin
            if (axi_ubuf_we)
                ub_mem[int'(axi_ubuf_addr)] = axi_ubuf_wdata;
            else
                ub_rdata_q <= ub_mem.exists(int'(axi_ubuf_addr)) ?
                              ub_mem[int'(axi_ubuf_addr)] : init_pat(axi_ubuf_addr);
        end
    end
    assign axi_ubuf_rdata = ub_rdata_q;

    always @(negedge clk) begin
        if (axi_ubuf_en) begin
            en_seen++;
            en_log.push_back({axi_ubuf_we, axi_ubuf_addr});
        end
    end

    // Reference model: word-addressed contents and the address rules.
    logic [63:0] ref_mem [int];
    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 8 == 0) && (a <= 32'h29FF * 8);
    endfunction
    function automatic logic [63:0] ref_read(input logic [31:0] a);
        int w = int'(a / 8);
        return ref_mem.exists(w) ? ref_mem[w] : init_pat(16'(w));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // All transaction tasks start and end at a falling edge.
    task automatic do_write(input logic [31:0] a, input logic [63:0] d,
                            input logic [7:0] s, input int hold);
        bit         legal = addr_ok(a) && (s == 8'hFF);
        logic [1:0] er    = legal ? 2'b00 : 2'b10;
        int         bound = 0;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        while (!(s_awready && s_wready) && bound < 20) begin
            @(negedge clk); bound++;
        end
        chk("wr_accept", 64'(bound < 20), 64'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        chk("wr_en_early", 64'(axi_ubuf_en), 64'd0);
        @(negedge clk);
        chk("wr_en", 64'(axi_ubuf_en), 64'(legal));
        chk("wr_we", 64'(axi_ubuf_we), 64'(legal));
        if (legal) begin
            chk("wr_addr", 64'(axi_ubuf_addr), 64'(a[18:3]));
            chk("wr_wdata", axi_ubuf_wdata, d);
        end
        chk("wr_bvalid_early", 64'(s_bvalid), 64'd0);
        @(negedge clk);
        chk("wr_bvalid", 64'(s_bvalid), 64'd1);
        chk("wr_bresp", 64'(s_bresp), 64'(er));
        repeat (hold) begin
            @(negedge clk);
            chk("wr_bvalid_hold", 64'(s_bvalid), 64'd1);
            chk("wr_bresp_hold", 64'(s_bresp), 64'(er));
            chk("wr_en_hold", 64'(axi_ubuf_en), 64'd0);
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        @(negedge clk);
        chk("wr_bvalid_drop", 64'(s_bvalid), 64'd0);
        if (legal) ref_mem[int'(a / 8)] = d;
        exp_en += int'(legal);
        $display("WR addr=%h strb=%h data=%h resp=%0d hold=%0d", a, s, d, er, hold);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold);
        bit          legal = addr_ok(a);
        logic [63:0] expd  = legal ? ref_read(a) : 64'h0;
        logic [1:0]  er    = legal ? 2'b00 : 2'b10;
        int          bound = 0;
        s_araddr = a; s_arvalid = 1'b1;
        while (!s_arready && bound < 20) begin
            @(negedge clk); bound++;
        end
        chk("rd_accept", 64'(bound < 20), 64'd1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("rd_en_early", 64'(axi_ubuf_en), 64'd0);
        @(negedge clk);
        chk("rd_en", 64'(axi_ubuf_en), 64'(legal));
        chk("rd_we", 64'(axi_ubuf_we), 64'd0);
        if (legal) chk("rd_addr", 64'(axi_ubuf_addr), 64'(a[18:3]));
        @(negedge clk);
        chk("rd_rvalid_early", 64'(s_rvalid), 64'd0);
        @(negedge clk);
        chk("rd_rvalid", 64'(s_rvalid), 64'd1);
        chk("rd_rdata", s_rdata, expd);
        chk("rd_rresp", 64'(s_rresp), 64'(er));
        repeat (hold) begin
            @(negedge clk);
            chk("rd_rvalid_hold", 64'(s_rvalid), 64'd1);
            chk("rd_rdata_hold", s_rdata, expd);
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
        @(negedge clk);
        chk("rd_rvalid_drop", 64'(s_rvalid), 64'd0);
        exp_en += int'(legal);
        $display("RD addr=%h data=%h resp=%0d hold=%0d", a, expd, er, hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [63:0] d, d2, rd_got;
        int          bound;
        bit          ok;

        s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0;
        s_bready = 0; s_arvalid = 0; s_araddr = 0; s_rready = 0;
        do_reset();
        @(negedge clk);
        chk("rst_awready", 64'(s_awready), 64'd1);
        chk("rst_wready", 64'(s_wready), 64'd1);
        chk("rst_arready", 64'(s_arready), 64'd1);
        chk("rst_bvalid", 64'(s_bvalid), 64'd0);
        chk("rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_bresp", 64'(s_bresp), 64'd0);
        chk("rst_rresp", 64'(s_rresp), 64'd0);
        chk("rst_rdata", s_rdata, 64'd0);
        chk("rst_en", 64'(axi_ubuf_en), 64'd0);
        chk("rst_we", 64'(axi_ubuf_we), 64'd0);
        chk("rst_addr", 64'(axi_ubuf_addr), 64'd0);
        chk("rst_wdata", axi_ubuf_wdata, 64'd0);

        // Basic legal write/read, illegal read and partial-strobe write.
        do_write(32'h0001_0000, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0);
        do_read(32'h0001_0000, 0);
        do_read(32'h0001_5000, 1);
        do_write(32'h0000_0100, 64'h1111_2222_3333_4444, 8'h0F, 0);
        do_read(32'h0000_0100, 0);
        // Address boundaries.
        do_write(32'h0001_4FF8, 64'hCAFE_F00D_5555_AAAA, 8'hFF, 1);
        do_read(32'h0001_4FF8, 2);
        do_read(32'h0000_0004, 0);
        do_read(32'h0008_0000, 0);
        do_write(32'h0001_5000, 64'h0, 8'hFF, 0);

        // bready held low 5 cycles while an AR is accepted behind the write.
        d = 64'h0BAD_CAFE_1234_5678;
        s_awaddr = 32'h0000_2000; s_wdata = d; s_wstrb = 8'hFF;
        s_awvalid = 1; s_wvalid = 1;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_wr_en", 64'(axi_ubuf_en), 64'd1);
        @(negedge clk);
        chk("stall_bvalid", 64'(s_bvalid), 64'd1);
        chk("stall_arready", 64'(s_arready), 64'd1);
        s_araddr = 32'h0000_2000; s_arvalid = 1;
        @(posedge clk); #1;
        s_arvalid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_bvalid_hold", 64'(s_bvalid), 64'd1);
            chk("stall_bresp_hold", 64'(s_bresp), 64'd0);
            chk("stall_no_en", 64'(axi_ubuf_en), 64'd0);
        end
        s_bready = 1;
        @(posedge clk); #1;
        s_bready = 0;
        ref_mem[int'(32'h2000 / 8)] = d;
        @(negedge clk);
        chk("stall_en_handshake_cycle", 64'(axi_ubuf_en), 64'd0);
        chk("stall_bvalid_drop", 64'(s_bvalid), 64'd0);
        @(negedge clk);
        chk("stall_rd_en", 64'(axi_ubuf_en), 64'd1);
        chk("stall_rd_we", 64'(axi_ubuf_we), 64'd0);
        chk("stall_rd_addr", 64'(axi_ubuf_addr), 64'h0400);
        @(negedge clk);
        @(negedge clk);
        chk("stall_rvalid", 64'(s_rvalid), 64'd1);
        chk("stall_rdata", s_rdata, ref_read(32'h2000));
        s_rready = 1;
        @(posedge clk); #1;
        s_rready = 0;
        @(negedge clk);
        exp_en += 2;
        $display("STALL write+read addr=00002000 data=%h", d);

        // Arbitration: AW, W and AR together right after reset -> write first;
        // a second write queued behind it -> read before that write.
        do_reset();
        en_log.delete();
        a  = 32'h0000_0800;
        d  = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        rd_got = 64'h0;
        s_bready = 1; s_rready = 1;
        s_awaddr = a; s_wdata = d; s_wstrb = 8'hFF; s_araddr = a;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        bound = 0;
        @(negedge clk);
        while (!(s_awready && s_wready) && bound < 20) begin
            @(negedge clk); bound++;
        end
        chk("arb_second_accept", 64'(bound < 20), 64'd1);
        s_wdata = d2; s_awvalid = 1; s_wvalid = 1;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        repeat (30) begin
            @(negedge clk);
            if (s_rvalid) rd_got = s_rdata;
        end
        s_bready = 0; s_rready = 0;
        chk("arb_en_count", 64'(en_log.size()), 64'd3);
        if (en_log.size() == 3) begin
            chk("arb_first_is_write", 64'(en_log[0]), 64'({1'b1, 16'h0100}));
            chk("arb_second_is_read", 64'(en_log[1]), 64'({1'b0, 16'h0100}));
            chk("arb_third_is_write", 64'(en_log[2]), 64'({1'b1, 16'h0100}));
        end
        chk("arb_read_data", rd_got, d);
        ref_mem[int'(a / 8)] = d2;
        exp_en += 3;
        $display("ARB write/read/write addr=%h d1=%h d2=%h", a, d, d2);
        do_read(a, 0);

        // Reset during the write strobe cycle abandons the write.
        s_awaddr = a; s_wdata = ~d2; s_wstrb = 8'hFF;
        s_awvalid = 1; s_wvalid = 1;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_en_before", 64'(axi_ubuf_en), 64'd1);
        exp_en += 1;
        #1 rst = 1;
        #1;
        chk("rstmid_en", 64'(axi_ubuf_en), 64'd0);
        chk("rstmid_we", 64'(axi_ubuf_we), 64'd0);
        chk("rstmid_addr", 64'(axi_ubuf_addr), 64'd0);
        chk("rstmid_wdata", axi_ubuf_wdata, 64'd0);
        chk("rstmid_awready", 64'(s_awready), 64'd1);
        @(negedge clk);
        rst = 0;
        s_bready = 1;
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (s_bvalid || axi_ubuf_en) ok = 0;
        end
        s_bready = 0;
        chk("rstmid_no_response", 64'(ok), 64'd1);
        $display("RSTMID write addr=%h abandoned", a);
        do_read(a, 0);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            int sel = $urandom_range(0, 9);
            logic [15:0] w = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15))
                                                         : 16'($urandom_range(0, 16'h29FF));
            case (sel)
                0:       a = {13'h0, w, 3'b000} | 32'($urandom_range(1, 7));
                1:       a = {13'h0, 16'($urandom_range(16'h2A00, 16'hFFFF)), 3'b000};
                2:       a = {13'($urandom_range(1, 8191)), w, 3'b000};
                default: a = {13'h0, w, 3'b000};
            endcase
            if ($urandom_range(0, 1) == 0)
                do_write(a, {$urandom, $urandom},
                         ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 254)) : 8'hFF,
                         $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end

        chk("en_total", 64'(en_seen), 64'(exp_en));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
